// File: rtl/ntp_ctrl_pkg.sv
// Shared definitions for the operand-stage forwarding control: forward-select
// encodings, instruction field positions and the in-flight tracker entry.
package ntp_ctrl_pkg;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_DM  = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  localparam int REG_AW = 5;

  localparam int RD_HI = 18;
  localparam int RD_LO = 14;
  localparam int RS_HI = 13;
  localparam int RS_LO = 9;
  localparam int RT_HI = 8;
  localparam int RT_LO = 4;

  typedef struct packed {
    logic              valid;
    logic              wr;
    logic              ld;
    logic [REG_AW-1:0] rd;
  } trk_entry_t;

  // An entry produces register r only if it is live and actually writes.
  function automatic logic entry_hit(input trk_entry_t e, input logic [REG_AW-1:0] r);
    return e.valid & e.wr & (e.rd == r);
  endfunction

endpackage

// File: rtl/fwd_prio_sel.sv
// Picks the forwarding source for one operand address; the youngest in-flight
// producer (T1 over T2 over T3) wins, otherwise the register bank is used.
module fwd_prio_sel
  import ntp_ctrl_pkg::*;
(
  input  logic [REG_AW-1:0] src_i,
  input  trk_entry_t        t1_i,
  input  trk_entry_t        t2_i,
  input  trk_entry_t        t3_i,
  output logic [1:0]        sel_o
);

  always_comb begin
    sel_o = FWD_REG;
    if (entry_hit(t1_i, src_i)) begin
      sel_o = FWD_EX;
    end else if (entry_hit(t2_i, src_i)) begin
      sel_o = FWD_DM;
    end else if (entry_hit(t3_i, src_i)) begin
      sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/operand_forward_ctrl.sv
// Operand-stage sequencer: tracks three older in-flight destinations, raises a
// one-cycle load-use stall and registers the A/B mux selects for the bank.
module operand_forward_ctrl
  import ntp_ctrl_pkg::*;
#(
  parameter int INS_W  = 24,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [INS_W-1:0]  ins,
  input  logic              id_valid,
  input  logic              reg_write_id,
  input  logic              load_id,
  input  logic              uses_imm_id,
  input  logic              flush,
  output logic              stall,
  output logic              issue_valid,
  output logic [1:0]        mux_sel_A,
  output logic [1:0]        mux_sel_B,
  output logic              imm_sel,
  output logic [ADDR_W-1:0] rw_ex
);

  logic [REG_AW-1:0] rd_id, rs_id, rt_id;
  logic [1:0]        sel_a, sel_b;
  logic              need_a, need_b, issue;
  logic              unused_ins_bits;

  trk_entry_t        t1_q, t2_q, t3_q, t1_d;
  logic [1:0]        mux_sel_a_q, mux_sel_a_d;
  logic [1:0]        mux_sel_b_q, mux_sel_b_d;
  logic              imm_sel_q, imm_sel_d;
  logic              issue_valid_q;
  logic [ADDR_W-1:0] rw_ex_q;

  assign rd_id = ins[RD_HI:RD_LO];
  assign rs_id = ins[RS_HI:RS_LO];
  assign rt_id = ins[RT_HI:RT_LO];
  assign unused_ins_bits = ^{ins[INS_W-1:RD_HI+1], ins[RT_LO-1:0]};

  fwd_prio_sel u_sel_a (
    .src_i (rs_id),
    .t1_i  (t1_q),
    .t2_i  (t2_q),
    .t3_i  (t3_q),
    .sel_o (sel_a)
  );

  fwd_prio_sel u_sel_b (
    .src_i (rt_id),
    .t1_i  (t1_q),
    .t2_i  (t2_q),
    .t3_i  (t3_q),
    .sel_o (sel_b)
  );

  // A T1 hit is exactly a select of FWD_EX; a load there has no result yet.
  assign need_a = id_valid;
  assign need_b = id_valid & ~uses_imm_id;
  assign stall  = t1_q.ld & ((need_a & (sel_a == FWD_EX)) |
                             (need_b & (sel_b == FWD_EX)));
  assign issue  = id_valid & ~stall;

  always_comb begin
    t1_d        = '0;
    mux_sel_a_d = FWD_REG;
    mux_sel_b_d = FWD_REG;
    imm_sel_d   = 1'b0;
    if (issue) begin
      t1_d.valid  = 1'b1;
      t1_d.wr     = reg_write_id;
      t1_d.ld     = load_id;
      t1_d.rd     = rd_id;
      mux_sel_a_d = sel_a;
      mux_sel_b_d = uses_imm_id ? FWD_REG : sel_b;
      imm_sel_d   = uses_imm_id;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t1_q          <= '0;
      t2_q          <= '0;
      t3_q          <= '0;
      mux_sel_a_q   <= FWD_REG;
      mux_sel_b_q   <= FWD_REG;
      imm_sel_q     <= 1'b0;
      issue_valid_q <= 1'b0;
      rw_ex_q       <= '0;
    end else if (flush) begin
      t1_q          <= '0;
      t2_q          <= '0;
      t3_q          <= '0;
      mux_sel_a_q   <= FWD_REG;
      mux_sel_b_q   <= FWD_REG;
      imm_sel_q     <= 1'b0;
      issue_valid_q <= 1'b0;
      rw_ex_q       <= '0;
    end else begin
      t1_q          <= t1_d;
      t2_q          <= t1_q;
      t3_q          <= t2_q;
      mux_sel_a_q   <= mux_sel_a_d;
      mux_sel_b_q   <= mux_sel_b_d;
      imm_sel_q     <= imm_sel_d;
      issue_valid_q <= issue;
      rw_ex_q       <= t1_d.rd;
    end
  end

  assign issue_valid = issue_valid_q;
  assign mux_sel_A   = mux_sel_a_q;
  assign mux_sel_B   = mux_sel_b_q;
  assign imm_sel     = imm_sel_q;
  assign rw_ex       = rw_ex_q;

endmodule

// File: tb/tb_operand_forward_ctrl.sv
// Directed bench for operand_forward_ctrl: forwarding distances, load-use
// stall, youngest-wins priority, immediate operand, flush and async reset.
module tb_operand_forward_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] ins;
  logic        id_valid, reg_write_id, load_id, uses_imm_id, flush;
  logic        stall, issue_valid, imm_sel;
  logic [1:0]  mux_sel_A, mux_sel_B;
  logic [4:0]  rw_ex;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  operand_forward_ctrl #(.INS_W(24), .ADDR_W(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .ins          (ins),
    .id_valid     (id_valid),
    .reg_write_id (reg_write_id),
    .load_id      (load_id),
    .uses_imm_id  (uses_imm_id),
    .flush        (flush),
    .stall        (stall),
    .issue_valid  (issue_valid),
    .mux_sel_A    (mux_sel_A),
    .mux_sel_B    (mux_sel_B),
    .imm_sel      (imm_sel),
    .rw_ex        (rw_ex)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic iv, input logic [1:0] a,
                         input logic [1:0] b, input logic im);
    chk({tag, ".issue_valid"}, {7'd0, issue_valid}, {7'd0, iv});
    chk({tag, ".mux_sel_A"},   {6'd0, mux_sel_A},   {6'd0, a});
    chk({tag, ".mux_sel_B"},   {6'd0, mux_sel_B},   {6'd0, b});
    chk({tag, ".imm_sel"},     {7'd0, imm_sel},     {7'd0, im});
    $display("txn %s: iv=%0b A=%0b B=%0b imm=%0b rw_ex=%0d", tag,
             issue_valid, mux_sel_A, mux_sel_B, imm_sel, rw_ex);
  endtask

  task automatic drv(input logic v, input logic wr, input logic ld, input logic imm,
                     input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    id_valid     = v;
    reg_write_id = wr;
    load_id      = ld;
    uses_imm_id  = imm;
    ins          = {5'd0, rd, rs, rt, 4'd0};
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Unrelated, non-writing filler instruction that names rd=3 as a decoy.
  task automatic nop_decoy;
    drv(1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 5'd20, 5'd21);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    drv(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    #2;
    chk_out("reset", 1'b0, 2'b00, 2'b00, 1'b0);
    chk("reset.stall", {7'd0, stall}, 8'd0);
    chk("reset.rw_ex", {3'd0, rw_ex}, 8'd0);
    #10 rst = 1'b0;

    // EX distance: write r3 then read rs=3
    drv(1'b1, 1'b1, 1'b0, 1'b0, 5'd3, 5'd1, 5'd2); tick();
    chk_out("alu_w3", 1'b1, 2'b00, 2'b00, 1'b0);
    chk("alu_w3.rw_ex", {3'd0, rw_ex}, 8'd3);
    drv(1'b1, 1'b0, 1'b0, 1'b0, 5'd9, 5'd3, 5'd4);
    #1 chk("ex_fwd.stall", {7'd0, stall}, 8'd0);
    tick();
    chk_out("ex_fwd", 1'b1, 2'b01, 2'b00, 1'b0);
    chk("ex_fwd.rw_ex", {3'd0, rw_ex}, 8'd9);

    // DM distance, with a non-writing decoy of rd=3 in between
    drv(1'b1, 1'b1, 1'b0, 1'b0, 5'd3, 5'd20, 5'd21); tick();
    nop_decoy();
    drv(1'b1, 1'b0, 1'b0, 1'b0, 5'd9, 5'd22, 5'd3); tick();
    chk_out("dm_fwd", 1'b1, 2'b00, 2'b10, 1'b0);

    // WB distance
    drv(1'b1, 1'b1, 1'b0, 1'b0, 5'd3, 5'd20, 5'd21); tick();
    nop_decoy(); nop_decoy();
    drv(1'b1, 1'b0, 1'b0, 1'b0, 5'd9, 5'd22, 5'd3); tick();
    chk_out("wb_fwd", 1'b1, 2'b00, 2'b11, 1'b0);

    // Out of range: three instructions in between
    drv(1'b1, 1'b1, 1'b0, 1'b0, 5'd3, 5'd20, 5'd21); tick();
    nop_decoy(); nop_decoy(); nop_decoy();
    drv(1'b1, 1'b0, 1'b0, 1'b0, 5'd9, 5'd22, 5'd3); tick();
    chk_out("no_fwd", 1'b1, 2'b00, 2'b00, 1'b0);

    // Load-use on rs: one stall cycle, then DM forward
    drv(1'b1, 1'b1, 1'b1, 1'b0, 5'd5, 5'd20, 5'd21); tick();
    drv(1'b1, 1'b0, 1'b0, 1'b0, 5'd9, 5'd5, 5'd20);
    #1 chk("ldu.stall1", {7'd0, stall}, 8'd1);
    tick();
    chk_out("ldu.bubble", 1'b0, 2'b00, 2'b00, 1'b0);
    chk("ldu.bubble.rw_ex", {3'd0, rw_ex}, 8'd0);
    chk("ldu.stall2", {7'd0, stall}, 8'd0);
    tick();
    chk_out("ldu.issue", 1'b1, 2'b10, 2'b00, 1'b0);

    // Load-use on rt stalls; the same rt with an immediate does not
    drv(1'b1, 1'b1, 1'b1, 1'b0, 5'd6, 5'd20, 5'd21); tick();
    drv(1'b1, 1'b0, 1'b0, 1'b0, 5'd9, 5'd20, 5'd6);
    #1 chk("ldu_rt.stall", {7'd0, stall}, 8'd1);
    tick(); tick();
    chk_out("ldu_rt.issue", 1'b1, 2'b00, 2'b10, 1'b0);
    drv(1'b1, 1'b1, 1'b1, 1'b0, 5'd6, 5'd20, 5'd21); tick();
    drv(1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 5'd20, 5'd6);
    #1 chk("ld_imm.stall", {7'd0, stall}, 8'd0);
    tick();
    chk_out("ld_imm", 1'b1, 2'b00, 2'b00, 1'b1);

    // Youngest wins: r7 in T1 and T3, read by both rs and rt
    drv(1'b1, 1'b1, 1'b0, 1'b0, 5'd7, 5'd20, 5'd21); tick();
    nop_decoy();
    drv(1'b1, 1'b1, 1'b0, 1'b0, 5'd7, 5'd20, 5'd21); tick();
    drv(1'b1, 1'b0, 1'b0, 1'b0, 5'd9, 5'd7, 5'd7); tick();
    chk_out("youngest", 1'b1, 2'b01, 2'b01, 1'b0);
    drv(1'b1, 1'b1, 1'b0, 1'b0, 5'd7, 5'd20, 5'd21); tick();
    nop_decoy();
    drv(1'b1, 1'b1, 1'b0, 1'b0, 5'd7, 5'd20, 5'd21); tick();
    drv(1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 5'd7, 5'd7); tick();
    chk_out("youngest_imm", 1'b1, 2'b01, 2'b00, 1'b1);

    // Register 0 forwards like any other
    drv(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd20, 5'd21); tick();
    drv(1'b1, 1'b0, 1'b0, 1'b0, 5'd9, 5'd0, 5'd20); tick();
    chk_out("reg0", 1'b1, 2'b01, 2'b00, 1'b0);

    // Flush while a consumer is stalled on a load of r2
    drv(1'b1, 1'b1, 1'b1, 1'b0, 5'd2, 5'd20, 5'd21); tick();
    drv(1'b1, 1'b0, 1'b0, 1'b0, 5'd9, 5'd2, 5'd20);
    #1 chk("flush.pre_stall", {7'd0, stall}, 8'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk_out("flush", 1'b0, 2'b00, 2'b00, 1'b0);
    chk("flush.rw_ex", {3'd0, rw_ex}, 8'd0);
    chk("flush.stall", {7'd0, stall}, 8'd0);
    tick();
    chk_out("flush.reader", 1'b1, 2'b00, 2'b00, 1'b0);

    // Async reset mid-cycle during a stall
    drv(1'b1, 1'b1, 1'b0, 1'b0, 5'd11, 5'd20, 5'd21); tick();
    drv(1'b1, 1'b1, 1'b1, 1'b0, 5'd12, 5'd11, 5'd20); tick();
    chk_out("pre_rst", 1'b1, 2'b01, 2'b00, 1'b0);
    drv(1'b1, 1'b0, 1'b0, 1'b0, 5'd9, 5'd12, 5'd11);
    #1 chk("pre_rst.stall", {7'd0, stall}, 8'd1);
    #1 rst = 1'b1;
    #1;
    chk_out("async_rst", 1'b0, 2'b00, 2'b00, 1'b0);
    chk("async_rst.stall", {7'd0, stall}, 8'd0);
    chk("async_rst.rw_ex", {3'd0, rw_ex}, 8'd0);
    #1 rst = 1'b0;
    tick();
    chk_out("post_rst", 1'b1, 2'b00, 2'b00, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/operand_forward_ctrl.md
Name: operand_forward_ctrl

Overview:
- Sequences the operand stage of the register bank: generates the registered `mux_sel_A`, `mux_sel_B` and `imm_sel` controls for the A/B operand muxes.
- Tracks the destination registers of the three older in-flight instructions and inserts load-use stall bubbles.
- Sits between instruction decode and the register bank; its outputs land in the same clock edge as the bank's AR/BR operand latches.

Parameters:
- INS_W, 24, instruction word width.
- ADDR_W, 5, register address width (32 registers).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ins  in  INS_W  instruction in ID. Fields: rd = ins[18:14], rs = ins[13:9], rt = ins[8:4].
- id_valid  in  1  ins holds a real instruction.
- reg_write_id  in  1  ID instruction writes rd.
- load_id  in  1  ID instruction is a load; result first available as ans_dm.
- uses_imm_id  in  1  B operand is the immediate; rt is not read.
- flush  in  1  discard ID and all tracked instructions.
- stall  out  1  combinational; hold fetch/ID this cycle.
- issue_valid  out  1  registered; an instruction entered the operand stage this edge.
- mux_sel_A  out  2  registered. 00 bank, 01 ans_ex, 10 ans_dm, 11 ans_wb.
- mux_sel_B  out  2  registered; same encoding as mux_sel_A.
- imm_sel  out  1  registered; B takes the immediate.
- rw_ex  out  ADDR_W  registered; rd of the T1 entry (debug/observability).

Behaviour:
- Tracker: three entries T1 (1 ahead), T2 (2 ahead), T3 (3 ahead). Each entry holds {valid, wr, ld, rd}.
- Shift rule, every posedge (not rst/flush): T3 <= T2, T2 <= T1, T1 <= new entry.
- New entry = ID fields when `id_valid & ~stall`; otherwise a bubble (valid = 0).
- Match definitions:
  - mX(r) = TX.valid & TX.wr & (TX.rd == r).
  - needA = id_valid. needB = id_valid & ~uses_imm_id.
- stall = (needA & m1(rs) & T1.ld) | (needB & m1(rt) & T1.ld). Combinational, no other sources.
- On an issuing edge (`id_valid & ~stall`):
  - mux_sel_A <= m1(rs) ? 01 : m2(rs) ? 10 : m3(rs) ? 11 : 00. Youngest producer wins.
  - mux_sel_B: same rule on rt. Forced to 00 when uses_imm_id.
  - imm_sel <= uses_imm_id.
  - issue_valid <= 1.
- On a non-issuing edge (stall, or no id_valid): mux_sel_A/B <= 00, imm_sel <= 0, issue_valid <= 0.
- Load-use: a load in T1 stalls exactly one cycle. Next cycle the load is in T2, stall drops, and the consumer forwards 10 (ans_dm).
- A load in T2 or T3 forwards normally with no stall.
- Non-write instructions (wr = 0) never match, even when the rd field is equal.
- Register 0 is ordinary: it is forwarded like any other register.
- rs == rt with a match: both muxes get the same select.
- flush (synchronous, priority over issue):
  - all T valid <= 0; outputs <= 00/0/0.
  - stall falls to 0 the cycle after flush.
- rst (asynchronous; applies immediately, including mid-stall):
  - all T valid = 0; mux_sel_A = mux_sel_B = 00; imm_sel = 0; issue_valid = 0; rw_ex = 0.
  - stall = 0 while in reset.
- rw_ex <= T1-next.rd on every edge; 0 for a bubble.

Decomposition:
- Shared package `ntp_ctrl_pkg`:
  - FWD_REG = 2'b00, FWD_EX = 2'b01, FWD_DM = 2'b10, FWD_WB = 2'b11.
  - Field-slice constants RD_HI/LO, RS_HI/LO, RT_HI/LO.
  - Tracker-entry struct typedef.
- One sub-module `fwd_prio_sel`: combinational 3-way priority compare of one source address against T1..T3, returning the 2-bit select. Instantiated twice (A and B).

Test Plan:
- ALU r3 <= ...; next ins reads rs = 3 -> issuing edge gives mux_sel_A = 01, stall = 0.
- Write r3, then unrelated instruction, then read rt = 3 -> mux_sel_B = 10. With two unrelated instructions in between -> 11. With three in between -> 00.
- Load r5, then ins reads rs = 5 -> stall = 1 for exactly one cycle and issue_valid = 0 on that edge. Next edge: mux_sel_A = 10, issue_valid = 1.
- Writes to r7 in T1 and T3, consumer reads r7 in both rs and rt -> both selects 01 (youngest wins). Same case with uses_imm_id = 1 -> mux_sel_B = 00, imm_sel = 1.
- Load r2 in T1 while consumer stalls; assert flush -> next edge: all selects 00, stall = 0, tracker empty (a reader of r2 now gets 00).
- Assert rst asynchronously mid-stream, between clock edges -> outputs go to 00/0/0 immediately. After release, the first instruction reading any register gets 00.
